// File: rtl/dualmem_stream_reader.sv
// dualmem_stream_reader: sequential read initiator for one port of a 64-bit
// dual-port RAM. It takes a (start address, word count) command and streams
// the words out on a valid/ready interface. A 2-entry buffer absorbs
// backpressure. When the buffer is empty, the word arriving from the RAM is
// presented directly, which keeps the first-word latency at two cycles.
// Optional feature macro: DUALMEM_RD_CHECKSUM_EN (XOR checksum of the
// accepted stream words).
module dualmem_stream_reader #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 64,
    parameter int LEN_W  = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [LEN_W-1:0]      cmd_len,
    output logic [DATA_W/8-1:0]   mem_en,
    output logic [DATA_W/8-1:0]   mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_W-1:0]     checksum
);

    localparam int NB = DATA_W / 8;
    localparam logic [LEN_W:0] MAX_LEN = (LEN_W + 1)'(1) << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [LEN_W-1:0]    r_remaining;
    logic                r_inflight;
    logic                r_inflight_last;
    logic [DATA_W-1:0]   r_buf0;
    logic [DATA_W-1:0]   r_buf1;
    logic                r_last0;
    logic                r_last1;
    logic [1:0]          r_count;
    logic                r_done;
    logic                w_issue;
    logic                w_accept;
    logic                w_pop;

    assign w_accept  = cmd_valid && cmd_ready;
    assign w_pop     = out_valid && out_ready;

    assign mem_en    = {NB{w_issue}};
    assign mem_we    = '0;
    assign mem_wdata = '0;
    assign mem_addr  = r_addr;
    assign done      = r_done;

    // The buffer head wins. With an empty buffer, the word returning from the RAM is shown directly.
    assign out_valid = (r_count != 2'd0) || r_inflight;
    assign out_data  = (r_count != 2'd0) ? r_buf0 :
                       (r_inflight ? mem_rdata : '0);
    assign out_last  = (r_count != 2'd0) ? r_last0 : (r_inflight && r_inflight_last);

    // Next-state logic. A read is issued only while buffered plus in-flight words stay below two.
    always_comb begin
        w_state_next = r_state;
        cmd_ready    = 1'b0;
        busy         = 1'b0;
        w_issue      = 1'b0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid && (cmd_len != '0)) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if ((r_count == 2'd0) || ((r_count == 2'd1) && !r_inflight)) begin
                    w_issue = 1'b1;
                    if (r_remaining == LEN_W'(1)) begin
                        w_state_next = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (w_pop && out_last) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Command state: state register, address and remaining count, and the done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= (w_accept && (cmd_len == '0)) ||
                       ((r_state == S_DRAIN) && w_pop && out_last);
            if (w_accept) begin
                r_addr      <= cmd_addr;
                r_remaining <= cmd_len;
            end else if (w_issue) begin
                r_addr      <= r_addr + ADDR_W'(1);
                r_remaining <= r_remaining - LEN_W'(1);
            end
        end
    end

    // Read tracking and the 2-entry output buffer. The returning word is stored unless it is consumed directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_buf0          <= '0;
            r_buf1          <= '0;
            r_last0         <= 1'b0;
            r_last1         <= 1'b0;
            r_count         <= 2'd0;
        end else begin
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (r_remaining == LEN_W'(1));
            case (r_count)
                2'd0: begin
                    if (r_inflight && !w_pop) begin
                        r_buf0  <= mem_rdata;
                        r_last0 <= r_inflight_last;
                        r_count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (r_inflight && w_pop) begin
                        r_buf0  <= mem_rdata;
                        r_last0 <= r_inflight_last;
                    end else if (r_inflight) begin
                        r_buf1  <= mem_rdata;
                        r_last1 <= r_inflight_last;
                        r_count <= 2'd2;
                    end else if (w_pop) begin
                        r_count <= 2'd0;
                    end
                end
                2'd2: begin
                    if (w_pop) begin
                        r_buf0  <= r_buf1;
                        r_last0 <= r_last1;
                        r_count <= 2'd1;
                    end
                end
                default: r_count <= 2'd0;
            endcase
        end
    end

`ifdef DUALMEM_RD_CHECKSUM_EN
    logic [DATA_W-1:0] r_checksum;

    // XOR of every word accepted on the stream, cleared when a new command is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_checksum <= '0;
        end else if (w_accept) begin
            r_checksum <= '0;
        end else if (w_pop) begin
            r_checksum <= r_checksum ^ out_data;
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = '0;
`endif

    // The issue rule guarantees a full buffer never coincides with a read in flight.
    assert property (@(posedge clk) disable iff (rst) !((r_count == 2'd2) && r_inflight));

    // Lengths above the RAM depth are illegal.
    assert property (@(posedge clk) disable iff (rst) w_accept |-> ({1'b0, cmd_len} <= MAX_LEN));

endmodule

// File: tb/tb_dualmem_stream_reader.sv
// Testbench for dualmem_stream_reader. A behavioural RAM and a queue-based
// reference model are built from the command rules: expected word i of a
// command = ram[(addr + i) mod depth]. Define DUALMEM_RD_CHECKSUM_EN to also
// check the checksum.
module tb_dualmem_stream_reader;

    localparam int AW    = 11;
    localparam int DW    = 64;
    localparam int LW    = 12;
    localparam int NB    = DW / 8;
    localparam int DEPTH = 2048;

    logic            clk = 1'b0;
    logic            rst;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [AW-1:0]   cmd_addr;
    logic [LW-1:0]   cmd_len;
    logic [NB-1:0]   mem_en;
    logic [NB-1:0]   mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic            out_last;
    logic            busy;
    logic            done;
    logic [DW-1:0]   checksum;

    logic [DW-1:0]   ram [DEPTH];

    int checks   = 0;
    int failures = 0;
    int first_valid_cyc;
    int last_pop_cyc;
    int done_cyc;

    always #5 clk = ~clk;

    dualmem_stream_reader #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .checksum  (checksum)
    );

    // RAM port model with one cycle of registered read latency.
    always @(posedge clk) begin
        if (mem_en != '0) mem_rdata <= ram[mem_addr];
    end

    task automatic fill_pattern();
        for (int k = 0; k < DEPTH; k++) ram[k] = 64'h1111_0000_0000_0000 + 64'(k);
    endtask

    task automatic fill_random();
        for (int k = 0; k < DEPTH; k++) ram[k] = {$urandom, $urandom};
    endtask

    // Runs one command from a negedge and returns at the negedge where done is seen.
    // mode 0: ready always high, mode 1: ready pattern 1,0,0 repeating, mode 2: random ready.
    task automatic do_cmd(input logic [AW-1:0] a, input logic [LW-1:0] n, input int mode, input string tag);
        logic [DW-1:0]    exp_q[$];
        logic [DW-1:0]    exp_x;
        logic [DW-1:0]    exp_cs;
        logic [DW-1:0]    prev_data;
        logic [AW-1:0]    ea;
        logic             prev_last;
        logic             r;
        bit               prev_stall;
        bit               seen_done;
        bit [DEPTH-1:0]   hit;
        int               issued;
        int               popped;
        int               dup;
        int               budget;
        exp_x = '0;
        prev_data = '0;
        prev_last = 1'b0;
        prev_stall = 1'b0;
        seen_done = 1'b0;
        hit = '0;
        issued = 0;
        popped = 0;
        dup = 0;
        for (int i = 0; i < int'(n); i++) begin
            exp_q.push_back(ram[a + AW'(i)]);
            exp_x ^= ram[a + AW'(i)];
        end
        first_valid_cyc = -1;
        last_pop_cyc = -1;
        done_cyc = -1;

        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s cmd_ready_before_accept: got %b need 1", tag, cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = n;
        out_ready = (mode == 0);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_addr  = AW'($urandom);
        cmd_len   = LW'($urandom);
        budget = 8 * int'(n) + 20;

        for (int cyc = 1; cyc <= budget && !seen_done; cyc++) begin
            if (cyc == 1) begin
                checks++;
                if (busy !== (n != '0)) begin
                    failures++;
                    $display("FAIL %s busy_cycle1: got %b need %b", tag, busy, (n != '0));
                end
                checks++;
                if (mem_we !== '0 || mem_wdata !== '0) begin
                    failures++;
                    $display("FAIL %s write_port_idle: got we=%h wdata=%h need 0", tag, mem_we, mem_wdata);
                end
            end
            if (mem_en !== '0) begin
                ea = a + AW'(issued);
                checks++;
                if (mem_en !== '1) begin
                    failures++;
                    $display("FAIL %s mem_en_lanes: got %h need ff", tag, mem_en);
                end
                checks++;
                if (mem_addr !== ea) begin
                    failures++;
                    $display("FAIL %s mem_addr: got %h need %h", tag, mem_addr, ea);
                end
                checks++;
                if ((issued - popped) >= 2 || issued >= int'(n)) begin
                    failures++;
                    $display("FAIL %s issue_when_full: got outstanding=%0d issued=%0d need outstanding<2 issued<%0d",
                             tag, issued - popped, issued, n);
                end
                if (hit[mem_addr]) dup++;
                hit[mem_addr] = 1'b1;
                issued++;
            end

            case (mode)
                0:       r = 1'b1;
                1:       r = ((cyc % 3) == 2);
                default: r = 1'($urandom_range(0, 1));
            endcase

            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last) begin
                    failures++;
                    $display("FAIL %s stall_stable: got v=%b d=%h l=%b need v=1 d=%h l=%b",
                             tag, out_valid, out_data, out_last, prev_data, prev_last);
                end
            end
            if (out_valid === 1'b1) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                checks++;
                if (popped >= int'(n)) begin
                    failures++;
                    $display("FAIL %s extra_word: got word %h after %0d words need none", tag, out_data, popped);
                end else if (r) begin
                    checks++;
                    if (out_data !== exp_q[popped]) begin
                        failures++;
                        $display("FAIL %s data[%0d]: got %h need %h", tag, popped, out_data, exp_q[popped]);
                    end
                    checks++;
                    if (out_last !== (popped == int'(n) - 1)) begin
                        failures++;
                        $display("FAIL %s last[%0d]: got %b need %b", tag, popped, out_last, (popped == int'(n) - 1));
                    end
                    popped++;
                    last_pop_cyc = cyc;
                end
            end
            prev_stall = (out_valid === 1'b1) && !r;
            prev_data  = out_data;
            prev_last  = out_last;
            out_ready  = r;

            if (done === 1'b1) begin
                seen_done = 1'b1;
                done_cyc  = cyc;
            end else begin
                @(negedge clk);
            end
        end

        checks++;
        if (!seen_done) begin
            failures++;
            $display("FAIL %s done_timeout: got no done within %0d cycles need done", tag, budget);
        end
        checks++;
        if (popped != int'(n)) begin
            failures++;
            $display("FAIL %s word_count: got %0d need %0d", tag, popped, n);
        end
        checks++;
        if (issued != int'(n) || dup != 0) begin
            failures++;
            $display("FAIL %s read_count: got issued=%0d dup=%0d need issued=%0d dup=0", tag, issued, dup, n);
        end
        if (seen_done) begin
            checks++;
            if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
                failures++;
                $display("FAIL %s done_state: got cmd_ready=%b busy=%b need 1 0", tag, cmd_ready, busy);
            end
`ifdef DUALMEM_RD_CHECKSUM_EN
            exp_cs = exp_x;
`else
            exp_cs = '0;
`endif
            checks++;
            if (checksum !== exp_cs) begin
                failures++;
                $display("FAIL %s checksum: got %h need %h", tag, checksum, exp_cs);
            end
        end
        if (mode == 0 && n != '0) begin
            checks++;
            if (first_valid_cyc != 2 || last_pop_cyc != int'(n) + 1 || done_cyc != int'(n) + 2) begin
                failures++;
                $display("FAIL %s timing: got first=%0d last=%0d done=%0d need 2 %0d %0d",
                         tag, first_valid_cyc, last_pop_cyc, done_cyc, int'(n) + 1, int'(n) + 2);
            end
        end
        $display("cmd %s addr=%h len=%0d mode=%0d words=%0d reads=%0d done_cyc=%0d",
                 tag, a, n, mode, popped, issued, done_cyc);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || mem_en !== '0 || mem_addr !== '0 ||
            out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0 || checksum !== '0) begin
            failures++;
            $display("FAIL reset_values: got rdy=%b busy=%b done=%b en=%h addr=%h v=%b l=%b d=%h cs=%h need 1 0 0 0 0 0 0 0 0",
                     cmd_ready, busy, done, mem_en, mem_addr, out_valid, out_last, out_data, checksum);
        end
        rst = 1'b0;
        @(negedge clk);
        $display("reset released");
    endtask

    task automatic test_basic();
        fill_pattern();
        do_cmd(11'h010, 12'd4, 0, "basic");
        checks++;
        if (done_cyc != 6) begin
            failures++;
            $display("FAIL basic_done_cycle: got %0d need 6", done_cyc);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL basic_done_pulse_width: got %b need 0", done);
        end
    endtask

    task automatic test_wrap();
        do_cmd(11'h7FE, 12'd4, 0, "wrap");
    endtask

    task automatic test_backpressure();
        do_cmd(11'h123, 12'd8, 1, "backpressure");
    endtask

    task automatic test_zero_len();
        do_cmd(11'h055, 12'd0, 0, "zero_len");
        checks++;
        if (done_cyc != 1 || first_valid_cyc != -1) begin
            failures++;
            $display("FAIL zero_len_timing: got done=%0d first_valid=%0d need 1 -1", done_cyc, first_valid_cyc);
        end
    endtask

    task automatic test_full();
        fill_random();
        do_cmd(11'h400, 12'd2048, 0, "full");
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t < 6; t++) begin
            do_cmd(AW'($urandom), LW'($urandom_range(1, 40)), 2, "random");
        end
    endtask

    task automatic test_reset_mid_command();
        int np;
        np = 0;
        cmd_valid = 1'b1;
        cmd_addr  = 11'h200;
        cmd_len   = 12'd10;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int cyc = 0; cyc < 30 && np < 3; cyc++) begin
            if (out_valid === 1'b1) np++;
            @(negedge clk);
        end
        checks++;
        if (np != 3) begin
            failures++;
            $display("FAIL midreset_progress: got %0d words need 3", np);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || mem_en !== '0 || mem_addr !== '0 ||
            out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0 || checksum !== '0) begin
            failures++;
            $display("FAIL midreset_values: got rdy=%b busy=%b done=%b en=%h addr=%h v=%b l=%b d=%h cs=%h need 1 0 0 0 0 0 0 0 0",
                     cmd_ready, busy, done, mem_en, mem_addr, out_valid, out_last, out_data, checksum);
        end
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || mem_en !== '0 || done !== 1'b0) begin
                failures++;
                $display("FAIL midreset_quiet[%0d]: got v=%b en=%h done=%b need 0 0 0", k, out_valid, mem_en, done);
            end
        end
        $display("cmd midreset addr=200 len=10 aborted after %0d words", np);
        do_cmd(11'h3FF, 12'd1, 0, "after_reset");
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        out_ready = 1'b0;
        fill_pattern();
        @(negedge clk);
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_len();
        test_back_to_back();
        test_full();
        test_reset_mid_command();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion need $finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dualmem_stream_reader.md
Name: dualmem_stream_reader

Overview:
- Read initiator for one port of the 64-bit x 2048-word dual-port RAM (11-bit word address, 8 byte-lane enables, 1-cycle registered read latency).
- Accepts a command (start address, word count), issues sequential reads and streams the words out on a valid/ready interface.
- A 2-entry output buffer absorbs backpressure, so no read data is lost or re-read.
- Used to drain boot/shared RAM contents towards DMA or debug paths.

Parameters:
- ADDR_W, 11, RAM word-address width (RAM depth = 2^ADDR_W).
- DATA_W, 64, RAM data width; byte lanes = DATA_W/8.
- LEN_W, 12, command length width; must be >= ADDR_W+1.

Ports:
- clk  in  1  single clock, also drives the RAM port clock.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when both cmd_valid and cmd_ready are high.
- cmd_addr  in  ADDR_W  start word address.
- cmd_len  in  LEN_W  number of words to read, 0..2^ADDR_W.
- mem_en  out  DATA_W/8  RAM port enable, all lanes driven together.
- mem_we  out  DATA_W/8  RAM write enable, constant 0.
- mem_addr  out  ADDR_W  RAM word address.
- mem_wdata  out  DATA_W  constant 0.
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after mem_en.
- out_valid  out  1  stream word valid.
- out_ready  in  1  stream sink ready.
- out_data  out  DATA_W  stream word.
- out_last  out  1  marks the final word of the command.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse after the last word is accepted, or after a zero-length command.
- checksum  out  DATA_W  see Optional Feature.

Behaviour:
- Reset values:
  - cmd_ready=1, busy=0, done=0.
  - mem_en=0, mem_addr=0.
  - out_valid=0, out_last=0, out_data=0, checksum=0.
  - Buffer emptied and in-flight read discarded.
  - Reset during RUN/DRAIN aborts the command; no further words are emitted.
- FSM states and transitions:
  - IDLE: cmd_ready=1.
    - Accept with cmd_len=0 -> done=1 next cycle, stay IDLE.
    - Accept with cmd_len!=0 -> RUN; latch addr and remaining=cmd_len.
  - RUN: issue reads; cmd_ready=0, busy=1.
    - Read issue condition: buffer occupancy + in-flight reads < 2.
    - On issue: mem_en=all-ones for one cycle, mem_addr=current addr; addr increments modulo 2^ADDR_W (2047 -> 0 wraps, no error); remaining decrements.
    - remaining reaching 0 -> DRAIN.
  - DRAIN: no reads issued.
    - When the last word is accepted (out_valid && out_ready && out_last) -> done=1 that next cycle and IDLE.
    - cmd_ready returns to 1 in the same cycle done pulses.
- Data capture: the mem_rdata of an issued read is captured into the buffer exactly one cycle after its mem_en cycle, in issue order.
- Timing:
  - Command accepted at edge 0 -> first mem_en in cycle 1 -> out_valid in cycle 2.
  - With out_ready held high: one word per cycle, no bubbles.
- Stream rules:
  - out_data and out_last hold stable while out_valid && !out_ready.
  - out_last=1 only on word cmd_len-1.
- Full-length command: cmd_len=2^ADDR_W reads every word exactly once, starting at cmd_addr and wrapping.
- Simultaneous events: buffer push and pop in the same cycle leave occupancy unchanged. Buffer-full with a read in flight is impossible by construction; an assertion checks this.
- Out-of-range length: cmd_len>2^ADDR_W is illegal; an assertion fires and the value is truncated to LEN_W bits as given.

Optional Feature:
- Macro: DUALMEM_RD_CHECKSUM_EN.
- Defined:
  - checksum = XOR of all words accepted on the stream for the current command.
  - Cleared when a command is accepted.
  - Final value is valid from the done pulse until the next command is accepted.
- Undefined: checksum tied to 0; no accumulator logic.

Test Plan:
- addr=0x010, len=4, RAM word k = 0x1111_0000_0000_0000+k, out_ready=1 -> words 0x..0010..0x..0013 on cycles 2..5, out_last on cycle 5, done on cycle 6.
- addr=0x7FE, len=4 -> reads 0x7FE, 0x7FF, 0x000, 0x001 in that order.
- len=8 with out_ready toggling 1,0,0,1,... -> all 8 words delivered in order with no duplicates, mem_en never issued while buffer+in-flight=2, out_data stable while stalled.
- len=0 -> no mem_en, no out_valid, done one cycle after acceptance.
- len=2048 from addr=0x400 -> exactly 2048 reads covering every address once; with DUALMEM_RD_CHECKSUM_EN, checksum equals the XOR of the whole RAM.
- rst asserted mid-command after 3 of 10 words -> outputs return to reset values next cycle; a new command len=1 then completes normally.
